// File: rtl/id_ex_operand_stage.sv
// ID/EX operand pipeline register with EX/MEM and MEM/WB forwarding, stall refresh and flush bubbles.
// Optional stall/flush performance counters are enabled with `define IDEX_PERF_EN.
module id_ex_operand_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
`ifdef IDEX_PERF_EN
    ,
    parameter int unsigned CNT_W  = 16
`endif
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [DATA_W-1:0] id_readReg1,
    input  logic [DATA_W-1:0] id_readReg2,
    input  logic [DATA_W-1:0] id_extImm,
    input  logic [4:0]        id_shamt,
    input  logic [1:0]        id_aluSource,
    input  logic              id_regWrite,
    input  logic [REG_AW-1:0] id_writeReg,
    input  logic              exmem_regWrite,
    input  logic [REG_AW-1:0] exmem_writeReg,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_regWrite,
    input  logic [REG_AW-1:0] memwb_writeReg,
    input  logic [DATA_W-1:0] memwb_result,
    output logic              ex_valid,
    output logic              ex_regWrite,
    output logic [REG_AW-1:0] ex_writeReg,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [DATA_W-1:0] ex_readReg1,
    output logic [DATA_W-1:0] ex_readReg2,
    output logic [DATA_W-1:0] ex_extImm,
    output logic [4:0]        ex_shamt,
    output logic [1:0]        ex_aluSource,
    output logic [1:0]        fwdA,
    output logic [1:0]        fwdB
`ifdef IDEX_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    logic              valid_q, valid_d;
    logic              regwrite_q, regwrite_d;
    logic [REG_AW-1:0] writereg_q, writereg_d;
    logic [REG_AW-1:0] rs_q, rs_d;
    logic [REG_AW-1:0] rt_q, rt_d;
    logic [DATA_W-1:0] rr1_q, rr1_d;
    logic [DATA_W-1:0] rr2_q, rr2_d;
    logic [DATA_W-1:0] extimm_q, extimm_d;
    logic [4:0]        shamt_q, shamt_d;
    logic [1:0]        alusrc_q, alusrc_d;

    assign ex_valid     = valid_q;
    assign ex_regWrite  = regwrite_q;
    assign ex_writeReg  = writereg_q;
    assign ex_rs        = rs_q;
    assign ex_rt        = rt_q;
    assign ex_extImm    = extimm_q;
    assign ex_shamt     = shamt_q;
    assign ex_aluSource = alusrc_q;

    // EX/MEM wins over MEM/WB; an empty stage or r0 never picks up a forwarded value.
    always_comb begin
        ex_readReg1 = rr1_q;
        fwdA        = 2'd0;
        if (valid_q && rs_q != '0) begin
            if (exmem_regWrite && exmem_writeReg == rs_q) begin
                ex_readReg1 = exmem_result;
                fwdA        = 2'd1;
            end else if (memwb_regWrite && memwb_writeReg == rs_q) begin
                ex_readReg1 = memwb_result;
                fwdA        = 2'd2;
            end
        end
    end

    always_comb begin
        ex_readReg2 = rr2_q;
        fwdB        = 2'd0;
        if (valid_q && rt_q != '0) begin
            if (exmem_regWrite && exmem_writeReg == rt_q) begin
                ex_readReg2 = exmem_result;
                fwdB        = 2'd1;
            end else if (memwb_regWrite && memwb_writeReg == rt_q) begin
                ex_readReg2 = memwb_result;
                fwdB        = 2'd2;
            end
        end
    end

    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        writereg_d = writereg_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        rr1_d      = rr1_q;
        rr2_d      = rr2_q;
        extimm_d   = extimm_q;
        shamt_d    = shamt_q;
        alusrc_d   = alusrc_q;
        if (flush) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            writereg_d = '0;
            rs_d       = '0;
            rt_d       = '0;
            rr1_d      = '0;
            rr2_d      = '0;
            extimm_d   = '0;
            shamt_d    = '0;
            alusrc_d   = '0;
        end else if (stall) begin
            // Re-latch the forwarded operands so they outlive a producer that retires mid-stall.
            rr1_d = ex_readReg1;
            rr2_d = ex_readReg2;
        end else begin
            valid_d    = id_valid;
            regwrite_d = id_regWrite;
            writereg_d = id_writeReg;
            rs_d       = id_rs;
            rt_d       = id_rt;
            extimm_d   = id_extImm;
            shamt_d    = id_shamt;
            alusrc_d   = id_aluSource;
            rr1_d      = (memwb_regWrite && id_rs != '0 && memwb_writeReg == id_rs)
                         ? memwb_result : id_readReg1;
            rr2_d      = (memwb_regWrite && id_rt != '0 && memwb_writeReg == id_rt)
                         ? memwb_result : id_readReg2;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            writereg_q <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            rr1_q      <= '0;
            rr2_q      <= '0;
            extimm_q   <= '0;
            shamt_q    <= '0;
            alusrc_q   <= '0;
        end else begin
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            writereg_q <= writereg_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            rr1_q      <= rr1_d;
            rr2_q      <= rr2_d;
            extimm_q   <= extimm_d;
            shamt_q    <= shamt_d;
            alusrc_q   <= alusrc_d;
        end
    end

`ifdef IDEX_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (flush && flush_cnt_q != '1) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
        if (stall && !flush && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: directed forwarding/stall/flush/reset cases plus a random stream.
module tb_id_ex_operand_stage;

    localparam int unsigned CNT_W = 16;

    logic        CLK, RST, stall, flush, id_valid;
    logic [4:0]  id_rs, id_rt, id_writeReg, id_shamt;
    logic [31:0] id_readReg1, id_readReg2, id_extImm;
    logic [1:0]  id_aluSource;
    logic        id_regWrite;
    logic        exmem_regWrite, memwb_regWrite;
    logic [4:0]  exmem_writeReg, memwb_writeReg;
    logic [31:0] exmem_result, memwb_result;
    logic        ex_valid, ex_regWrite;
    logic [4:0]  ex_writeReg, ex_rs, ex_rt, ex_shamt;
    logic [31:0] ex_readReg1, ex_readReg2, ex_extImm;
    logic [1:0]  ex_aluSource, fwdA, fwdB;
`ifdef IDEX_PERF_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

    id_ex_operand_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .CLK(CLK), .RST(RST), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_readReg1(id_readReg1), .id_readReg2(id_readReg2),
        .id_extImm(id_extImm), .id_shamt(id_shamt), .id_aluSource(id_aluSource),
        .id_regWrite(id_regWrite), .id_writeReg(id_writeReg),
        .exmem_regWrite(exmem_regWrite), .exmem_writeReg(exmem_writeReg), .exmem_result(exmem_result),
        .memwb_regWrite(memwb_regWrite), .memwb_writeReg(memwb_writeReg), .memwb_result(memwb_result),
        .ex_valid(ex_valid), .ex_regWrite(ex_regWrite), .ex_writeReg(ex_writeReg),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_readReg1(ex_readReg1), .ex_readReg2(ex_readReg2),
        .ex_extImm(ex_extImm), .ex_shamt(ex_shamt), .ex_aluSource(ex_aluSource),
        .fwdA(fwdA), .fwdB(fwdB)
`ifdef IDEX_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        v, rw;
        logic [4:0]  wr, rs, rt;
        logic [31:0] r1, r2, imm;
        logic [4:0]  sh;
        logic [1:0]  src, fa, fb;
    } out_t;

    // Architectural view of the stage: what instruction sits in EX and what it read.
    typedef struct {
        logic        v, rw;
        logic [4:0]  wr, rs, rt;
        logic [31:0] r1, r2, imm;
        logic [4:0]  sh;
        logic [1:0]  src;
    } st_t;

    st_t  m;
    out_t expq[$];
    int   tests = 0;
    int   fails = 0;
    int   m_scnt = 0;
    int   m_fcnt = 0;

    function automatic out_t act_out();
        out_t a;
        a.v = ex_valid; a.rw = ex_regWrite; a.wr = ex_writeReg; a.rs = ex_rs; a.rt = ex_rt;
        a.r1 = ex_readReg1; a.r2 = ex_readReg2; a.imm = ex_extImm; a.sh = ex_shamt;
        a.src = ex_aluSource; a.fa = fwdA; a.fb = fwdB;
        return a;
    endfunction

    // Value EX should see for a source register: youngest in-flight producer, else what was read.
    function automatic void source_value(input logic [4:0] idx, input logic [31:0] lat,
                                         output logic [31:0] val, output logic [1:0] sel);
        val = lat;
        sel = 2'd0;
        if (m.v && idx != 0) begin
            if (exmem_regWrite && exmem_writeReg == idx) begin
                val = exmem_result; sel = 2'd1;
            end else if (memwb_regWrite && memwb_writeReg == idx) begin
                val = memwb_result; sel = 2'd2;
            end
        end
    endfunction

    task automatic model_reset();
        m = '{v: 1'b0, rw: 1'b0, wr: 5'd0, rs: 5'd0, rt: 5'd0, r1: 32'd0, r2: 32'd0,
              imm: 32'd0, sh: 5'd0, src: 2'd0};
        m_scnt = 0;
        m_fcnt = 0;
    endtask

    task automatic clr();
        stall = 0; flush = 0; id_valid = 0; id_rs = 0; id_rt = 0; id_writeReg = 0; id_shamt = 0;
        id_readReg1 = 0; id_readReg2 = 0; id_extImm = 0; id_aluSource = 0; id_regWrite = 0;
        exmem_regWrite = 0; exmem_writeReg = 0; exmem_result = 0;
        memwb_regWrite = 0; memwb_writeReg = 0; memwb_result = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Push this cycle's expected outputs, then advance the model across the next edge.
    task automatic issue();
        out_t e;
        logic [31:0] va, vb;
        logic [1:0]  sa, sb;
        source_value(m.rs, m.r1, va, sa);
        source_value(m.rt, m.r2, vb, sb);
        e.v = m.v; e.rw = m.rw; e.wr = m.wr; e.rs = m.rs; e.rt = m.rt;
        e.r1 = va; e.r2 = vb; e.imm = m.imm; e.sh = m.sh; e.src = m.src; e.fa = sa; e.fb = sb;
        expq.push_back(e);
        @(posedge CLK);
        if (flush) begin
            if (m_fcnt < (1 << CNT_W) - 1) m_fcnt++;
        end else if (stall) begin
            if (m_scnt < (1 << CNT_W) - 1) m_scnt++;
        end
        if (flush) begin
            m = '{v: 1'b0, rw: 1'b0, wr: 5'd0, rs: 5'd0, rt: 5'd0, r1: 32'd0, r2: 32'd0,
                  imm: 32'd0, sh: 5'd0, src: 2'd0};
        end else if (stall) begin
            m.r1 = va;
            m.r2 = vb;
        end else begin
            m.v = id_valid; m.rw = id_regWrite; m.wr = id_writeReg; m.rs = id_rs; m.rt = id_rt;
            m.imm = id_extImm; m.sh = id_shamt; m.src = id_aluSource;
            m.r1 = (memwb_regWrite && id_rs != 0 && memwb_writeReg == id_rs) ? memwb_result : id_readReg1;
            m.r2 = (memwb_regWrite && id_rt != 0 && memwb_writeReg == id_rt) ? memwb_result : id_readReg2;
        end
        #1;
    endtask

    always @(negedge CLK) begin
        if (expq.size() > 0) begin
            out_t e, a;
            e = expq.pop_front();
            a = act_out();
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL stage_outputs @%0t: got %h expected %h", $time, a, e);
            end
        end
    end

    initial begin
        clr();
        model_reset();
        RST = 1;
        repeat (2) @(posedge CLK);
        #1;
        tests++;
        if (act_out() !== '0) begin
            fails++;
            $display("FAIL reset_state: got %h expected 0", act_out());
        end
        RST = 0;
        issue();

        // Plain advance
        id_valid = 1; id_rs = 3; id_readReg1 = 32'h11; id_aluSource = 2'd3;
        issue();
        clr(); #1;
        chk("advance_r1", ex_readReg1, 32'h11);
        chk("advance_fwdA", 32'(fwdA), 32'd0);
        chk("alusrc3_pass", 32'(ex_aluSource), 32'd3);
        issue();

        // Forwarding priority, held by a stall while producers change
        id_valid = 1; id_rs = 5; id_readReg1 = 32'h5;
        issue();
        clr(); stall = 1;
        exmem_regWrite = 1; exmem_writeReg = 5; exmem_result = 32'hAA;
        memwb_regWrite = 1; memwb_writeReg = 5; memwb_result = 32'hBB;
        #1;
        chk("prio_exmem_r1", ex_readReg1, 32'hAA);
        chk("prio_exmem_fwdA", 32'(fwdA), 32'd1);
        exmem_regWrite = 0; #1;
        chk("prio_memwb_r1", ex_readReg1, 32'hBB);
        chk("prio_memwb_fwdA", 32'(fwdA), 32'd2);
        issue();
        clr();
        issue();

        // Stall refresh survives the producer retiring
        id_valid = 1; id_rt = 7; id_readReg2 = 32'h3;
        issue();
        clr(); stall = 1;
        exmem_regWrite = 1; exmem_writeReg = 7; exmem_result = 32'h42;
        issue();
        exmem_regWrite = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("stall_refresh_r2", ex_readReg2, 32'h42);
            chk("stall_refresh_fwdB", 32'(fwdB), 32'd0);
            issue();
        end
        clr();

        // Write-through at capture
        id_valid = 1; id_rt = 9; id_readReg2 = 32'h1;
        memwb_regWrite = 1; memwb_writeReg = 9; memwb_result = 32'h99;
        issue();
        clr(); #1;
        chk("writethrough_r2", ex_readReg2, 32'h99);
        issue();

        // Register 0 is neither written through nor forwarded
        id_valid = 1; id_rs = 0; id_readReg1 = 32'h55;
        memwb_regWrite = 1; memwb_writeReg = 0; memwb_result = 32'h77;
        issue();
        clr();
        exmem_regWrite = 1; exmem_writeReg = 0; exmem_result = 32'hFF;
        #1;
        chk("r0_r1", ex_readReg1, 32'h55);
        chk("r0_fwdA", 32'(fwdA), 32'd0);
        issue();

        // Flush beats a simultaneous stall
        clr();
        id_valid = 1; id_regWrite = 1; id_writeReg = 3; id_rs = 2; id_readReg1 = 32'h123;
        issue();
        clr(); stall = 1; flush = 1;
        issue();
        clr(); #1;
        chk("flush_valid", 32'(ex_valid), 32'd0);
        chk("flush_regwrite", 32'(ex_regWrite), 32'd0);
        issue();

        // Random stream
        for (int n = 0; n < 300; n++) begin
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 9) == 0);
            id_valid = ($urandom_range(0, 3) != 0);
            if (id_valid) begin
                id_rs = 5'($urandom_range(0, 7)); id_rt = 5'($urandom_range(0, 7));
                id_readReg1 = $urandom; id_readReg2 = $urandom; id_extImm = $urandom;
                id_shamt = 5'($urandom_range(0, 31)); id_aluSource = 2'($urandom_range(0, 3));
                id_regWrite = 1'($urandom_range(0, 1)); id_writeReg = 5'($urandom_range(0, 7));
            end else begin
                id_rs = 0; id_rt = 0; id_readReg1 = 0; id_readReg2 = 0; id_extImm = 0;
                id_shamt = 0; id_aluSource = 0; id_regWrite = 0; id_writeReg = 0;
            end
            exmem_regWrite = 1'($urandom_range(0, 1)); exmem_writeReg = 5'($urandom_range(0, 7));
            exmem_result = $urandom;
            memwb_regWrite = 1'($urandom_range(0, 1)); memwb_writeReg = 5'($urandom_range(0, 7));
            memwb_result = $urandom;
            issue();
        end

`ifdef IDEX_PERF_EN
        #1;
        chk("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
        chk("flush_cnt", 32'(flush_cnt), 32'(m_fcnt));
`endif

        // Asynchronous reset mid-cycle, with a forwarding match present
        clr();
        id_valid = 1; id_rs = 4; id_readReg1 = 32'h1234; id_regWrite = 1;
        issue();
        clr();
        exmem_regWrite = 1; exmem_writeReg = 4; exmem_result = 32'hAB;
        #6;
        RST = 1;
        #1;
        tests++;
        if (act_out() !== '0) begin
            fails++;
            $display("FAIL async_reset: got %h expected 0", act_out());
        end
        @(posedge CLK);
        #1;
        RST = 0;
        model_reset();
        clr();
        issue();

`ifdef IDEX_PERF_EN
        stall = 1; flush = 1;
        issue();
        stall = 1; flush = 0;
        repeat ((1 << CNT_W) + 2) @(posedge CLK);
        #1;
        chk("stall_cnt_saturated", 32'(stall_cnt), 32'((1 << CNT_W) - 1));
        chk("flush_cnt_after_sat", 32'(flush_cnt), 32'd1);
        clr();
`endif

        repeat (2) @(posedge CLK);
        #1;
        chk("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
